// File: rtl/dict_ram.sv
// Simple-dual-port LZW dictionary RAM with write-first bypass, 1/2-cycle read latency and a clear sequencer.
// Define DICT_RAM_PARITY_EN to store an even-parity bit per word and expose rd_parity_err.
module dict_ram #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DEPTH      = 16,
    parameter int                    RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  clr_start,
    output logic                  clr_busy,
`ifdef DICT_RAM_PARITY_EN
    output logic                  clr_done,
    output logic                  rd_parity_err
`else
    output logic                  clr_done
`endif
);

`ifdef DICT_RAM_PARITY_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    generate
        if (!(RD_LATENCY == 1 || RD_LATENCY == 2)) begin : g_bad_latency
            $error("dict_ram: RD_LATENCY must be 1 or 2");
        end
        if (DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
            $error("dict_ram: DEPTH exceeds 2**ADDR_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
    state_t state, next_state;

    logic [ADDR_WIDTH-1:0] cnt;
    logic [MW-1:0]         mem [DEPTH];

    function automatic logic [MW-1:0] encode(input logic [DATA_WIDTH-1:0] d);
`ifdef DICT_RAM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        clr_busy   = 1'b0;
        clr_done   = 1'b0;
        case (state)
            IDLE:  if (clr_start) next_state = CLEAR;
            CLEAR: begin
                clr_busy = 1'b1;
                if (cnt == LAST) next_state = DONE;
            end
            DONE: begin
                clr_done   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                cnt <= '0;
        else if (state == CLEAR) cnt <= cnt + 1'b1;
        else                    cnt <= '0;
    end

    logic idle, wr_hit, rd_hit, rd_in_range, bypass;
    assign idle        = (state == IDLE);
    assign wr_hit      = idle && wr_en && ({1'b0, wr_addr} < DEPTH_W);
    assign rd_hit      = idle && rd_en;
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
    assign bypass      = wr_hit && (wr_addr == rd_addr);

    // Array is deliberately not reset; the clear sequencer owns initialisation.
    always_ff @(posedge clk) begin
        if (state == CLEAR) mem[cnt]     <= encode(CLEAR_VAL);
        else if (wr_hit)    mem[wr_addr] <= encode(wr_data);
    end

    logic [MW-1:0]         rd_word;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_err;

    always_comb begin
        rd_word = '0;
        s1_data = '0;
        s1_err  = 1'b0;
        if (rd_in_range) begin
            if (bypass) begin
                s1_data = wr_data;
            end else begin
                rd_word = mem[rd_addr];
                s1_data = rd_word[DATA_WIDTH-1:0];
                s1_err  = ^rd_word;
            end
        end
    end

    logic [DATA_WIDTH-1:0] q1_data;
    logic                  q1_valid, q1_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1_data  <= '0;
            q1_valid <= 1'b0;
            q1_err   <= 1'b0;
        end else begin
            q1_valid <= rd_hit;
            q1_err   <= rd_hit && (MW > DATA_WIDTH) && s1_err;
            if (rd_hit) q1_data <= s1_data;
        end
    end

    logic                  out_err;

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] q2_data;
            logic                  q2_valid, q2_err;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q2_data  <= '0;
                    q2_valid <= 1'b0;
                    q2_err   <= 1'b0;
                end else begin
                    q2_data  <= q1_data;
                    q2_valid <= q1_valid;
                    q2_err   <= q1_err;
                end
            end
            assign rd_data  = q2_data;
            assign rd_valid = q2_valid;
            assign out_err  = q2_err;
        end else begin : g_lat1
            assign rd_data  = q1_data;
            assign rd_valid = q1_valid;
            assign out_err  = q1_err;
        end
    endgenerate

`ifdef DICT_RAM_PARITY_EN
    assign rd_parity_err = out_err;
`else
    logic unused_err;
    assign unused_err = out_err;
`endif

endmodule

// File: tb/tb_dict_ram.sv
// Directed self-checking bench for dict_ram: latency-1 instance plus a latency-2 instance on shared stimulus.
module tb_dict_ram;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en, clr_start;
    logic [3:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data, rd_data2;
    logic        rd_valid, rd_valid2, clr_busy, clr_busy2, clr_done, clr_done2;
`ifdef DICT_RAM_PARITY_EN
    logic        perr, perr2;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dict_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .RD_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .clr_start(clr_start), .clr_busy(clr_busy),
`ifdef DICT_RAM_PARITY_EN
        .clr_done(clr_done), .rd_parity_err(perr)
`else
        .clr_done(clr_done)
`endif
    );

    dict_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .RD_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2),
        .clr_start(clr_start), .clr_busy(clr_busy2),
`ifdef DICT_RAM_PARITY_EN
        .clr_done(clr_done2), .rd_parity_err(perr2)
`else
        .clr_done(clr_done2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; rd_en = 1'b0; clr_start = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
    endtask

    task automatic write(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, {31'b0, rd_valid}, 32'd1);
        check(tag, rd_data, exp);
    endtask

    int n_busy, n_done, n_rdv;

    initial begin
        idle_inputs();
        rst = 1'b1;
        #12;
        check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_clr_busy", {31'b0, clr_busy}, 32'd0);
        check("rst_clr_done", {31'b0, clr_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // basic write then read, one-cycle latency
        write(4'd2, 32'hABCDE123);
        rd_en = 1'b1; rd_addr = 4'd2;
        tick();
        rd_en = 1'b0;
        check("rd1_valid", {31'b0, rd_valid}, 32'd1);
        check("rd1_data", rd_data, 32'hABCDE123);
        tick();
        check("rd1_valid_drop", {31'b0, rd_valid}, 32'd0);

        // write-first bypass and independent addresses
        write(4'd6, 32'h66666666);
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h0000BEEF;
        rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        check("bypass_data", rd_data, 32'h0000BEEF);
        wr_addr = 4'd5; wr_data = 32'h12345678; rd_addr = 4'd6;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("indep_old6", rd_data, 32'h66666666);
        read_check("after_wr5", 4'd5, 32'h12345678);

        // latency-2 pipeline on dut2
        write(4'd0, 32'h00000A00);
        write(4'd1, 32'h00000A01);
        write(4'd2, 32'h00000A02);
        rd_en = 1'b1; rd_addr = 4'd0;
        tick();
        check("l2_e1_valid", {31'b0, rd_valid2}, 32'd0);
        check("l1_e1_data", rd_data, 32'h00000A00);
        rd_addr = 4'd1;
        tick();
        check("l2_e2_valid", {31'b0, rd_valid2}, 32'd1);
        check("l2_e2_data", rd_data2, 32'h00000A00);
        rd_addr = 4'd2;
        tick();
        rd_en = 1'b0;
        check("l2_e3_valid", {31'b0, rd_valid2}, 32'd1);
        check("l2_e3_data", rd_data2, 32'h00000A01);
        tick();
        check("l2_e4_valid", {31'b0, rd_valid2}, 32'd1);
        check("l2_e4_data", rd_data2, 32'h00000A02);
        tick();
        check("l2_e5_valid", {31'b0, rd_valid2}, 32'd0);

        // fill, then full clear with writes/reads attempted while busy
        for (int i = 0; i < 16; i++) write(4'(i), 32'hF0000000 + 32'(i));
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        n_busy = 0; n_done = 0; n_rdv = 0;
        for (int i = 0; i < 30; i++) begin
            if (clr_busy) n_busy++;
            if (clr_done) n_done++;
            if (rd_valid) n_rdv++;
            wr_en = clr_busy; wr_addr = 4'd7; wr_data = 32'hDEADDEAD;
            rd_en = clr_busy; rd_addr = 4'd7;
            clr_start = clr_busy;
            tick();
        end
        idle_inputs();
        check("clr_busy_cycles", 32'(n_busy), 32'd16);
        check("clr_done_pulses", 32'(n_done), 32'd1);
        check("clr_no_rd_valid", 32'(n_rdv), 32'd0);
        check("clr_idle_after", {31'b0, clr_busy}, 32'd0);
        for (int i = 0; i < 16; i++) read_check($sformatf("clr_word%0d", i), 4'(i), 32'd0);

        // reset in the middle of a clear
        for (int i = 0; i < 16; i++) write(4'(i), 32'hA5A50000 + 32'(i));
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'b0, clr_busy}, 32'd0);
        check("midrst_done", {31'b0, clr_done}, 32'd0);
        tick();
        check("midrst_done_later", {31'b0, clr_done}, 32'd0);
        rst = 1'b0;
        tick();
        check("midrst_no_done", {31'b0, clr_done}, 32'd0);
        for (int i = 0; i < 16; i++)
            read_check($sformatf("midrst_word%0d", i), 4'(i), (i < 7) ? 32'd0 : 32'hA5A50000 + 32'(i));

`ifdef DICT_RAM_PARITY_EN
        dut.mem[3] = dut.mem[3] ^ 33'd1;
        read_check("par_bad_data", 4'd3, 32'd1);
        check("par_bad_err", {31'b0, perr}, 32'd1);
        read_check("par_clean_data", 4'd4, 32'd0);
        check("par_clean_err", {31'b0, perr}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end
endmodule
